// File: rtl/ex_operand_stage_if.sv
// ex_operand_stage_if: bundle of signals between the decode/hazard/write-back side and the
// ID/EX operand stage.
//   id_*     decoded instruction fields from ID
//   wb_*     write-back port, used for forwarding and held-operand refresh
//   stall    hold stage contents; flush kills the incoming instruction
//   ex_*     registered operands and control presented to the ALU / later stages
// master: drives ID/WB/hazard signals, observes EX outputs. slave: the operand stage.
interface ex_operand_stage_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [RA_W-1:0] id_rs1_addr;
  logic [RA_W-1:0] id_rs2_addr;
  logic [XLEN-1:0] id_imm;
  logic            id_a_sel;
  logic            id_b_sel;
  logic [3:0]      id_aluop;
  logic [RA_W-1:0] id_rd;
  logic            id_reg_we;
  logic            wb_we;
  logic [RA_W-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            stall;
  logic            flush;
  logic            ex_valid;
  logic [XLEN-1:0] ex_a;
  logic [XLEN-1:0] ex_b;
  logic [3:0]      ex_aluop;
  logic [XLEN-1:0] ex_store_data;
  logic [RA_W-1:0] ex_rd;
  logic            ex_reg_we;
  logic [XLEN-1:0] ex_pc;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_rs1_addr, id_rs2_addr, id_imm,
    output id_a_sel, id_b_sel, id_aluop, id_rd, id_reg_we, wb_we, wb_rd, wb_data,
    output stall, flush,
    input  ex_valid, ex_a, ex_b, ex_aluop, ex_store_data, ex_rd, ex_reg_we, ex_pc
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_rs1_addr, id_rs2_addr, id_imm,
    input  id_a_sel, id_b_sel, id_aluop, id_rd, id_reg_we, wb_we, wb_rd, wb_data,
    input  stall, flush,
    output ex_valid, ex_a, ex_b, ex_aluop, ex_store_data, ex_rd, ex_reg_we, ex_pc
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register and ALU operand select.
// Forwards the write-back value onto rs1/rs2, picks A (rs1 or PC) and B (rs2 or immediate),
// and registers them with the rest of the EX control. Priority per edge:
// rst > flush > stall > load.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  ex_operand_stage_if.slave (ID fields, WB port, stall/flush in; EX fields out)
`ifndef ALU_ADD
`define ALU_ADD 4'b0000
`endif

module ex_operand_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input logic                clk,
  input logic                rst,
  ex_operand_stage_if.slave  bus
);

  logic            valid_q, valid_d;
  logic            reg_we_q, reg_we_d;
  logic [RA_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] store_q, store_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [3:0]      aluop_q, aluop_d;
  // Source tracking for refreshing operands while stalled.
  logic [RA_W-1:0] rs1_q, rs1_d;
  logic [RA_W-1:0] rs2_q, rs2_d;
  logic            a_sel_q, a_sel_d;
  logic            b_sel_q, b_sel_d;

  logic [XLEN-1:0] fwd1, fwd2;
  logic            hold_hit1, hold_hit2;

  // x0 is hard-wired zero, so a write-back to it must never be forwarded.
  always_comb begin
    fwd1 = bus.id_rs1_data;
    fwd2 = bus.id_rs2_data;
    if (bus.wb_we && (bus.wb_rd == bus.id_rs1_addr) && (bus.id_rs1_addr != '0)) begin
      fwd1 = bus.wb_data;
    end
    if (bus.wb_we && (bus.wb_rd == bus.id_rs2_addr) && (bus.id_rs2_addr != '0)) begin
      fwd2 = bus.wb_data;
    end
  end

  assign hold_hit1 = bus.wb_we && (bus.wb_rd == rs1_q) && (rs1_q != '0);
  assign hold_hit2 = bus.wb_we && (bus.wb_rd == rs2_q) && (rs2_q != '0);

  always_comb begin
    valid_d  = valid_q;
    reg_we_d = reg_we_q;
    rd_d     = rd_q;
    a_d      = a_q;
    b_d      = b_q;
    store_d  = store_q;
    pc_d     = pc_q;
    aluop_d  = aluop_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    a_sel_d  = a_sel_q;
    b_sel_d  = b_sel_q;
    if (bus.flush) begin
      // Bubble: only the valid bits drop, data fields keep their last value.
      valid_d  = 1'b0;
      reg_we_d = 1'b0;
    end else if (bus.stall) begin
      // Held instruction must not keep a value that write-back has since replaced.
      if (hold_hit1 && !a_sel_q) begin
        a_d = bus.wb_data;
      end
      if (hold_hit2) begin
        store_d = bus.wb_data;
        if (!b_sel_q) begin
          b_d = bus.wb_data;
        end
      end
    end else begin
      valid_d  = bus.id_valid;
      reg_we_d = bus.id_valid & bus.id_reg_we;
      rd_d     = bus.id_rd;
      a_d      = bus.id_a_sel ? bus.id_pc : fwd1;
      b_d      = bus.id_b_sel ? bus.id_imm : fwd2;
      store_d  = fwd2;
      pc_d     = bus.id_pc;
      aluop_d  = bus.id_aluop;
      rs1_d    = bus.id_rs1_addr;
      rs2_d    = bus.id_rs2_addr;
      a_sel_d  = bus.id_a_sel;
      b_sel_d  = bus.id_b_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      reg_we_q <= 1'b0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      store_q  <= '0;
      pc_q     <= '0;
      aluop_q  <= `ALU_ADD;
      rs1_q    <= '0;
      rs2_q    <= '0;
      a_sel_q  <= 1'b0;
      b_sel_q  <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      reg_we_q <= reg_we_d;
      rd_q     <= rd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      store_q  <= store_d;
      pc_q     <= pc_d;
      aluop_q  <= aluop_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      a_sel_q  <= a_sel_d;
      b_sel_q  <= b_sel_d;
    end
  end

  always_comb begin
    bus.ex_valid      = valid_q;
    bus.ex_reg_we     = reg_we_q;
    bus.ex_rd         = rd_q;
    bus.ex_a          = a_q;
    bus.ex_b          = b_q;
    bus.ex_store_data = store_q;
    bus.ex_pc         = pc_q;
    bus.ex_aluop      = aluop_q;
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed-vector bench for ex_operand_stage.
module tb_ex_operand_stage;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  ex_operand_stage_if #(.XLEN(32), .RA_W(5)) bus ();

  ex_operand_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.id_valid = 1'b0;  bus.id_pc = '0;       bus.id_rs1_data = '0; bus.id_rs2_data = '0;
    bus.id_rs1_addr = '0; bus.id_rs2_addr = '0; bus.id_imm = '0;      bus.id_a_sel = 1'b0;
    bus.id_b_sel = 1'b0;  bus.id_aluop = '0;    bus.id_rd = '0;       bus.id_reg_we = 1'b0;
    bus.wb_we = 1'b0;     bus.wb_rd = '0;       bus.wb_data = '0;
    bus.stall = 1'b0;     bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    // Load a non-trivial instruction, then pulse rst mid-cycle with stall+flush asserted.
    bus.id_valid = 1'b1; bus.id_pc = 32'h0000_0abc; bus.id_rs1_data = 32'h1234_5678;
    bus.id_rs2_data = 32'h9abc_def0; bus.id_imm = 32'h0000_0055; bus.id_b_sel = 1'b1;
    bus.id_aluop = 4'ha; bus.id_rd = 5'd17; bus.id_reg_we = 1'b1; bus.id_rs1_addr = 5'd2;
    tick();
    n_checks++;
    if (bus.ex_valid !== 1'b1) begin
      n_fail++; $display("FAIL reset_preload_valid got %b exp 1", bus.ex_valid);
    end
    bus.stall = 1'b1; bus.flush = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.ex_valid, bus.ex_reg_we, bus.ex_rd} !== 7'd0) begin
      n_fail++; $display("FAIL reset_ctl got %b%b %0d exp 0 0 0", bus.ex_valid, bus.ex_reg_we,
                         bus.ex_rd);
    end
    n_checks++;
    if ({bus.ex_a, bus.ex_b, bus.ex_store_data, bus.ex_pc} !== 128'd0) begin
      n_fail++; $display("FAIL reset_data got a=%h b=%h sd=%h pc=%h exp all 0", bus.ex_a,
                         bus.ex_b, bus.ex_store_data, bus.ex_pc);
    end
    n_checks++;
    if (bus.ex_aluop !== 4'h0) begin
      n_fail++; $display("FAIL reset_aluop got %h exp 0", bus.ex_aluop);
    end
    tick();
    n_checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_a !== 32'h0) begin
      n_fail++; $display("FAIL reset_hold got v=%b a=%h exp 0 0", bus.ex_valid, bus.ex_a);
    end
    drive_idle();
    rst = 1'b0;
  endtask

  task automatic test_plain_load();
    drive_idle();
    bus.id_valid = 1'b1; bus.id_rs1_addr = 5'd1; bus.id_rs1_data = 32'h0000_0005;
    bus.id_rs2_addr = 5'd2; bus.id_rs2_data = 32'h0000_0022; bus.id_imm = 32'hffff_fffc;
    bus.id_b_sel = 1'b1; bus.id_aluop = 4'h0; bus.id_rd = 5'd3; bus.id_reg_we = 1'b1;
    bus.id_pc = 32'h0000_0100;
    tick();
    n_checks++;
    if (bus.ex_a !== 32'h5 || bus.ex_b !== 32'hffff_fffc) begin
      n_fail++; $display("FAIL load_ab got %h %h exp 00000005 fffffffc", bus.ex_a, bus.ex_b);
    end
    n_checks++;
    if ({bus.ex_valid, bus.ex_reg_we, bus.ex_rd} !== {1'b1, 1'b1, 5'd3}) begin
      n_fail++; $display("FAIL load_ctl got %b %b %0d exp 1 1 3", bus.ex_valid, bus.ex_reg_we,
                         bus.ex_rd);
    end
    n_checks++;
    if (bus.ex_store_data !== 32'h22 || bus.ex_pc !== 32'h100 || bus.ex_aluop !== 4'h0) begin
      n_fail++; $display("FAIL load_misc got sd=%h pc=%h op=%h exp 22 100 0",
                         bus.ex_store_data, bus.ex_pc, bus.ex_aluop);
    end
  endtask

  task automatic test_forwarding();
    drive_idle();
    bus.id_valid = 1'b1; bus.id_rs1_addr = 5'd7; bus.id_rs1_data = 32'h1111_1111;
    bus.id_rs2_addr = 5'd7; bus.id_rs2_data = 32'h2222_2222; bus.id_aluop = 4'h5;
    bus.wb_we = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 32'hdead_beef;
    tick();
    n_checks++;
    if (bus.ex_a !== 32'hdead_beef) begin
      n_fail++; $display("FAIL fwd_rs1 got %h exp deadbeef", bus.ex_a);
    end
    n_checks++;
    if (bus.ex_b !== 32'hdead_beef || bus.ex_store_data !== 32'hdead_beef) begin
      n_fail++; $display("FAIL fwd_rs2 got b=%h sd=%h exp deadbeef", bus.ex_b, bus.ex_store_data);
    end
    n_checks++;
    if (bus.ex_aluop !== 4'h5) begin
      n_fail++; $display("FAIL aluop_pass got %h exp 5", bus.ex_aluop);
    end
    // x0 must not forward even with a matching write-back.
    bus.id_rs1_addr = 5'd0; bus.id_rs2_addr = 5'd0; bus.wb_rd = 5'd0;
    tick();
    n_checks++;
    if (bus.ex_a !== 32'h1111_1111 || bus.ex_store_data !== 32'h2222_2222) begin
      n_fail++; $display("FAIL fwd_x0 got a=%h sd=%h exp 11111111 22222222", bus.ex_a,
                         bus.ex_store_data);
    end
    // Mismatched write-back address: no forwarding.
    bus.id_rs1_addr = 5'd8; bus.wb_rd = 5'd9;
    tick();
    n_checks++;
    if (bus.ex_a !== 32'h1111_1111) begin
      n_fail++; $display("FAIL fwd_nomatch got %h exp 11111111", bus.ex_a);
    end
  endtask

  task automatic test_stall_refresh();
    drive_idle();
    bus.id_valid = 1'b1; bus.id_rs1_addr = 5'd4; bus.id_rs1_data = 32'h44;
    bus.id_rs2_addr = 5'd9; bus.id_rs2_data = 32'h1; bus.id_rd = 5'd5; bus.id_reg_we = 1'b1;
    bus.id_aluop = 4'h3; bus.id_pc = 32'h200;
    tick();
    n_checks++;
    if (bus.ex_b !== 32'h1) begin
      n_fail++; $display("FAIL stall_pre_b got %h exp 1", bus.ex_b);
    end
    // New ID contents must be ignored while stalled.
    bus.stall = 1'b1; bus.id_rs1_data = 32'h5555; bus.id_rs2_data = 32'h6666;
    bus.id_rd = 5'd30; bus.id_aluop = 4'hf; bus.id_pc = 32'h300; bus.id_valid = 1'b0;
    tick();
    n_checks++;
    if ({bus.ex_a, bus.ex_b, bus.ex_pc} !== {32'h44, 32'h1, 32'h200}) begin
      n_fail++; $display("FAIL stall_c1 got a=%h b=%h pc=%h exp 44 1 200", bus.ex_a, bus.ex_b,
                         bus.ex_pc);
    end
    bus.wb_we = 1'b1; bus.wb_rd = 5'd9; bus.wb_data = 32'hcafe_0000;
    tick();
    bus.wb_we = 1'b0;
    n_checks++;
    if (bus.ex_b !== 32'hcafe_0000 || bus.ex_store_data !== 32'hcafe_0000) begin
      n_fail++; $display("FAIL stall_refresh got b=%h sd=%h exp cafe0000", bus.ex_b,
                         bus.ex_store_data);
    end
    n_checks++;
    if ({bus.ex_valid, bus.ex_reg_we, bus.ex_rd, bus.ex_aluop, bus.ex_a} !==
        {1'b1, 1'b1, 5'd5, 4'h3, 32'h44}) begin
      n_fail++; $display("FAIL stall_others got v=%b we=%b rd=%0d op=%h a=%h exp 1 1 5 3 44",
                         bus.ex_valid, bus.ex_reg_we, bus.ex_rd, bus.ex_aluop, bus.ex_a);
    end
    tick();
    n_checks++;
    if (bus.ex_b !== 32'hcafe_0000 || bus.ex_pc !== 32'h200) begin
      n_fail++; $display("FAIL stall_c3 got b=%h pc=%h exp cafe0000 200", bus.ex_b, bus.ex_pc);
    end
    // First non-stall edge loads the pending ID inputs (id_valid=0 here).
    bus.stall = 1'b0;
    tick();
    n_checks++;
    if ({bus.ex_valid, bus.ex_reg_we, bus.ex_a, bus.ex_rd} !== {1'b0, 1'b0, 32'h5555, 5'd30})
    begin
      n_fail++; $display("FAIL stall_release got v=%b we=%b a=%h rd=%0d exp 0 0 5555 30",
                         bus.ex_valid, bus.ex_reg_we, bus.ex_a, bus.ex_rd);
    end
  endtask

  task automatic test_stall_refresh_sel();
    // B from immediate: refresh must reach store data only; A from rs1 is refreshed.
    drive_idle();
    bus.id_valid = 1'b1; bus.id_rs1_addr = 5'd4; bus.id_rs1_data = 32'h44;
    bus.id_rs2_addr = 5'd4; bus.id_rs2_data = 32'h45; bus.id_b_sel = 1'b1; bus.id_imm = 32'h77;
    tick();
    bus.stall = 1'b1; bus.wb_we = 1'b1; bus.wb_rd = 5'd4; bus.wb_data = 32'h0bad_f00d;
    tick();
    n_checks++;
    if ({bus.ex_a, bus.ex_b, bus.ex_store_data} !== {32'h0bad_f00d, 32'h77, 32'h0bad_f00d}) begin
      n_fail++; $display("FAIL stall_sel got a=%h b=%h sd=%h exp 0badf00d 77 0badf00d",
                         bus.ex_a, bus.ex_b, bus.ex_store_data);
    end
    // A from PC must not be refreshed.
    bus.stall = 1'b0; bus.wb_we = 1'b0; bus.id_a_sel = 1'b1; bus.id_pc = 32'h880;
    tick();
    bus.stall = 1'b1; bus.wb_we = 1'b1; bus.wb_data = 32'h1357;
    tick();
    n_checks++;
    if (bus.ex_a !== 32'h880 || bus.ex_store_data !== 32'h1357) begin
      n_fail++; $display("FAIL stall_pcsel got a=%h sd=%h exp 880 1357", bus.ex_a,
                         bus.ex_store_data);
    end
  endtask

  task automatic test_flush();
    drive_idle();
    bus.id_valid = 1'b1; bus.id_rs1_addr = 5'd3; bus.id_rs1_data = 32'haaaa;
    bus.id_rs2_addr = 5'd6; bus.id_rs2_data = 32'hbbbb; bus.id_reg_we = 1'b1; bus.id_rd = 5'd12;
    tick();
    n_checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_reg_we !== 1'b1) begin
      n_fail++; $display("FAIL flush_pre got v=%b we=%b exp 1 1", bus.ex_valid, bus.ex_reg_we);
    end
    bus.flush = 1'b1; bus.stall = 1'b1; bus.id_rs1_data = 32'hcccc; bus.id_rs2_data = 32'hdddd;
    tick();
    n_checks++;
    if ({bus.ex_valid, bus.ex_reg_we, bus.ex_a, bus.ex_b} !== {2'b00, 32'haaaa, 32'hbbbb}) begin
      n_fail++; $display("FAIL flush_stall got v=%b we=%b a=%h b=%h exp 0 0 aaaa bbbb",
                         bus.ex_valid, bus.ex_reg_we, bus.ex_a, bus.ex_b);
    end
    // Flush alone also holds data and does not apply stall refresh.
    bus.stall = 1'b0; bus.wb_we = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'hee;
    tick();
    n_checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_a !== 32'haaaa || bus.ex_rd !== 5'd12) begin
      n_fail++; $display("FAIL flush_only got v=%b a=%h rd=%0d exp 0 aaaa 12", bus.ex_valid,
                         bus.ex_a, bus.ex_rd);
    end
  endtask

  task automatic test_pc_select();
    drive_idle();
    bus.id_valid = 1'b1; bus.id_a_sel = 1'b1; bus.id_pc = 32'h0000_1000; bus.id_b_sel = 1'b1;
    bus.id_imm = 32'h4; bus.id_rs2_addr = 5'd6; bus.id_rs2_data = 32'h66;
    bus.wb_we = 1'b1; bus.wb_rd = 5'd6; bus.wb_data = 32'habcd;
    tick();
    n_checks++;
    if ({bus.ex_a, bus.ex_b, bus.ex_store_data} !== {32'h1000, 32'h4, 32'habcd}) begin
      n_fail++; $display("FAIL pc_sel got a=%h b=%h sd=%h exp 1000 4 abcd", bus.ex_a, bus.ex_b,
                         bus.ex_store_data);
    end
    n_checks++;
    if (bus.ex_pc !== 32'h1000 || bus.ex_reg_we !== 1'b0) begin
      n_fail++; $display("FAIL pc_sel_ctl got pc=%h we=%b exp 1000 0", bus.ex_pc, bus.ex_reg_we);
    end
  endtask

  task automatic test_back_to_back();
    // Consecutive loads each land one cycle later.
    drive_idle();
    for (int i = 0; i < 4; i++) begin
      bus.id_valid = i[0]; bus.id_reg_we = 1'b1; bus.id_rs1_data = 32'h100 + i;
      bus.id_rs1_addr = 5'd1; bus.id_rd = 5'(i + 20);
      tick();
      n_checks++;
      if ({bus.ex_valid, bus.ex_reg_we, bus.ex_a, bus.ex_rd} !==
          {i[0], i[0], 32'h100 + i, 5'(i + 20)}) begin
        n_fail++; $display("FAIL b2b_%0d got v=%b we=%b a=%h rd=%0d", i, bus.ex_valid,
                           bus.ex_reg_we, bus.ex_a, bus.ex_rd);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    drive_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_plain_load();
    test_forwarding();
    test_stall_refresh();
    test_stall_refresh_sel();
    test_flush();
    test_pc_select();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
